// File: rtl/fbuffer_copy_ctrl.sv
// ---------------------------------------------------------------------------
// fbuffer_copy_ctrl
//
// Copies FB_WORDS words from the back framebuffer into the front framebuffer
// after a CPU request. The copy can be restricted to vertical blank.
//
// Build option:
//   FBCOPY_VBLANK_GATE_EN  defined   : copying waits for vblank=1, and issue
//                                      stops while vblank=0.
//                          undefined : vblank is ignored. WAIT_VB lasts one
//                                      cycle, and issue depends only on
//                                      cpu_we.
//
// Ports:
//   clk, reset         system clock; synchronous active-high reset
//   start              copy request pulse (ignored while copy_pending=1)
//   vblank             VGA vertical-blank indicator
//   cpu_we/addr/wdata  CPU write request to the back buffer
//   back_addr/we/wdata/re, back_rdata
//                      single back-buffer port. Read data returns one cycle
//                      after back_re.
//   front_we/addr/wdata
//                      front-buffer write port
//   copy_pending       a copy is requested or in progress
//   dbg_state_o        current FSM state (IDLE=0, WAIT_VB=1, COPY=2, FLUSH=3)
// ---------------------------------------------------------------------------
module fbuffer_copy_ctrl #(
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 8,
  parameter int FB_WORDS = 19200
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              vblank,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [ADDR_W-1:0] back_addr,
  output logic              back_we,
  output logic [DATA_W-1:0] back_wdata,
  output logic              back_re,
  input  logic [DATA_W-1:0] back_rdata,
  output logic              front_we,
  output logic [ADDR_W-1:0] front_addr,
  output logic [DATA_W-1:0] front_wdata,
  output logic              copy_pending,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VB = 2'd1,
    COPY    = 2'd2,
    FLUSH   = 2'd3
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(FB_WORDS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] addr_q;
  logic              valid_q;
  logic              issue;
  logic              vb_ok;

`ifdef FBCOPY_VBLANK_GATE_EN
  assign vb_ok = vblank;
`else
  // vblank has no effect in this build.
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign vb_ok         = 1'b1;
`endif

  // Next-state and issue logic. A read is issued only in COPY, only when
  // vblank allows it, and only when the CPU is not using the back-buffer port
  // this cycle. rd_ptr advances only on an issue. After the last word it stays
  // at LAST_PTR, so no word is skipped or repeated across stalls.
  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    issue    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = WAIT_VB;
          rd_ptr_d = '0;
        end
      end
      WAIT_VB: begin
        if (vb_ok) state_d = COPY;
      end
      COPY: begin
        issue = vb_ok & ~cpu_we;
        if (issue) begin
          if (rd_ptr_q == LAST_PTR) state_d = FLUSH;
          else                      rd_ptr_d = rd_ptr_q + 1'b1;
        end
      end
      FLUSH: begin
        // The last read word is written to the front buffer in this cycle.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      valid_q  <= 1'b0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      valid_q  <= issue;
      if (issue) addr_q <= rd_ptr_q;
    end
  end

  // Back-buffer port handshake. The port carries at most one operation per
  // cycle. When cpu_we=1, it is a write of cpu_wdata to cpu_addr and
  // back_re=0. When issue=1, it is a read of rd_ptr, and back_rdata holds that
  // word in the next cycle. That word is written to the front buffer in the
  // same cycle through front_we/front_addr, with no back-pressure. A CPU write
  // always wins arbitration and stalls the copy for that cycle.
  assign back_we      = cpu_we;
  assign back_wdata   = cpu_wdata;
  assign back_re      = issue;
  assign back_addr    = issue ? rd_ptr_q : cpu_addr;

  assign front_we     = valid_q;
  assign front_addr   = addr_q;
  assign front_wdata  = back_rdata;

  assign copy_pending = (state_q != IDLE);
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_fbuffer_copy_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fbuffer_copy_ctrl
//
// Bench for fbuffer_copy_ctrl with FB_WORDS=4 and a 16-word back memory.
// It builds with or without FBCOPY_VBLANK_GATE_EN and follows the same macro.
//
// The reference model works at transaction level. An accepted start
// (start=1 while no copy is outstanding and reset=0) queues four expected
// front writes {addr, mem[addr]} for addr 0..3. A copy stays outstanding until
// the fourth of those writes appears. Reset drops any outstanding copy.
// ---------------------------------------------------------------------------
module tb_fbuffer_copy_ctrl;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int FBW = 4;

  logic          clk = 1'b0;
  logic          reset, start, vblank, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [AW-1:0] back_addr;
  logic          back_we, back_re;
  logic [DW-1:0] back_wdata;
  logic [DW-1:0] back_rdata = '0;
  logic          front_we;
  logic [AW-1:0] front_addr;
  logic [DW-1:0] front_wdata;
  logic          copy_pending;
  logic [1:0]    dbg_state;

  fbuffer_copy_ctrl #(.ADDR_W(AW), .DATA_W(DW), .FB_WORDS(FBW)) dut (
    .clk(clk), .reset(reset), .start(start), .vblank(vblank),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .back_addr(back_addr), .back_we(back_we), .back_wdata(back_wdata),
    .back_re(back_re), .back_rdata(back_rdata),
    .front_we(front_we), .front_addr(front_addr), .front_wdata(front_wdata),
    .copy_pending(copy_pending), .dbg_state_o(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- back memory (1-cycle read latency) ----------------
  logic [DW-1:0] mem [0:15];
  always @(posedge clk) begin
    if (back_re === 1'b1) back_rdata <= mem[back_addr];
    if (back_we === 1'b1) mem[back_addr] <= back_wdata;
  end

  // ---------------- scoreboard state ----------------
  logic [AW+DW-1:0] exp_q[$];
  int  fw_cyc[$];
  bit  model_busy = 1'b0;
  bit  mon_en = 1'b0;
  int  pend_cnt = 0;
  int  n_checks = 0;
  int  n_fail = 0;

  // Bus monitor and front-write scoreboard.
  always @(negedge clk) begin
    bit accept;
    logic [AW+DW-1:0] e;
    if (mon_en) begin
      accept = (reset === 1'b0) && (start === 1'b1) && !model_busy;
      n_checks++;
      if (copy_pending !== model_busy) begin
        n_fail++;
        $display("FAIL pending_track: copy_pending=%0b required=%0b cyc=%0d", copy_pending, model_busy, cyc);
      end
      n_checks++;
      if (back_we !== cpu_we) begin
        n_fail++;
        $display("FAIL back_we_follow: back_we=%0b required=%0b cyc=%0d", back_we, cpu_we, cyc);
      end
      if (cpu_we === 1'b1) begin
        n_checks++;
        if (back_re !== 1'b0 || back_addr !== cpu_addr || back_wdata !== cpu_wdata) begin
          n_fail++;
          $display("FAIL cpu_priority: re=%0b addr=%0h wdata=%0h required re=0 addr=%0h wdata=%0h cyc=%0d",
                   back_re, back_addr, back_wdata, cpu_addr, cpu_wdata, cyc);
        end
      end
`ifdef FBCOPY_VBLANK_GATE_EN
      if (back_re === 1'b1) begin
        n_checks++;
        if (vblank !== 1'b1) begin
          n_fail++;
          $display("FAIL read_outside_vblank: back_re=1 vblank=%0b required vblank=1 cyc=%0d", vblank, cyc);
        end
      end
`endif
      if (copy_pending === 1'b1) pend_cnt++;
      if (front_we === 1'b1) begin
        fw_cyc.push_back(cyc);
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL front_unexpected: addr=%0h data=%0h required no write cyc=%0d", front_addr, front_wdata, cyc);
        end else begin
          e = exp_q.pop_front();
          if ({front_addr, front_wdata} !== e) begin
            n_fail++;
            $display("FAIL front_write: addr=%0h data=%0h required addr=%0h data=%0h cyc=%0d",
                     front_addr, front_wdata, e[AW+DW-1:DW], e[DW-1:0], cyc);
          end
          if (exp_q.size() == 0) model_busy = 1'b0;
        end
      end
      if (reset === 1'b1) begin
        model_busy = 1'b0;
        exp_q.delete();
      end else if (accept) begin
        model_busy = 1'b1;
        for (int i = 0; i < FBW; i++) exp_q.push_back({AW'(i), mem[i]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_mem();
    for (int i = 0; i < 16; i++) mem[i] = DW'($urandom_range(0, 255));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Wait until the DUT and the model are both idle, up to a fixed cycle budget.
  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!model_busy && copy_pending === 1'b0 && exp_q.size() == 0) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; start = 1'b0; vblank = 1'b0; cpu_we = 1'b0;
    cpu_addr = '0; cpu_wdata = '0;
    load_mem();
    tick(); tick();
    n_checks++;
    if (copy_pending !== 1'b0 || front_we !== 1'b0 || back_re !== 1'b0 || back_we !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: pending=%0b front_we=%0b back_re=%0b back_we=%0b required all 0",
               copy_pending, front_we, back_re, back_we);
    end
    reset = 1'b0;
    tick();
    mon_en = 1'b1;
  endtask

  task automatic test_basic();
    int s;
    bit ok;
    load_mem();
    vblank = 1'b1;
    fw_cyc.delete();
    pend_cnt = 0;
    pulse_start();
    s = cyc;
    wait_done(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL basic_timeout: copy not finished required finish within 300 cycles"); end
    n_checks++;
    if (fw_cyc.size() != FBW) begin
      n_fail++; $display("FAIL basic_count: writes=%0d required %0d", fw_cyc.size(), FBW);
    end else begin
      for (int k = 0; k < FBW; k++) begin
        n_checks++;
        if (fw_cyc[k] != s + 2 + k) begin
          n_fail++; $display("FAIL basic_timing: write %0d at cyc %0d required cyc %0d", k, fw_cyc[k], s + 2 + k);
        end
      end
    end
    // WAIT_VB + four COPY cycles + FLUSH.
    n_checks++;
    if (pend_cnt != 6) begin
      n_fail++; $display("FAIL basic_pending_len: %0d cycles required 6", pend_cnt);
    end
  endtask

`ifdef FBCOPY_VBLANK_GATE_EN
  task automatic test_vblank_hold();
    bit ok;
    load_mem();
    vblank = 1'b0;
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (back_re !== 1'b0 || front_we !== 1'b0 || copy_pending !== 1'b1) begin
        n_fail++;
        $display("FAIL vblank_hold: re=%0b fwe=%0b pending=%0b required 0 0 1 cyc=%0d", back_re, front_we, copy_pending, cyc);
      end
      tick();
    end
    vblank = 1'b1;
    fw_cyc.delete();
    wait_done(ok);
    n_checks++;
    if (!ok || fw_cyc.size() != FBW) begin
      n_fail++; $display("FAIL vblank_hold_done: ok=%0b writes=%0d required 1 %0d", ok, fw_cyc.size(), FBW);
    end
  endtask

  task automatic test_vblank_pause();
    bit ok;
    load_mem();
    vblank = 1'b1;
    pulse_start();
    tick();          // now in COPY, word 0 issued this cycle
    tick();          // word 1 issued this cycle
    tick();
    vblank = 1'b0;
    #1;
    n_checks++;
    if (back_re !== 1'b0 || front_we !== 1'b1 || front_addr !== 4'd1) begin
      n_fail++;
      $display("FAIL pause_inflight: re=%0b fwe=%0b faddr=%0h required 0 1 1", back_re, front_we, front_addr);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (back_re !== 1'b0 || front_we !== 1'b0 || copy_pending !== 1'b1) begin
        n_fail++;
        $display("FAIL pause_hold: re=%0b fwe=%0b pending=%0b required 0 0 1", back_re, front_we, copy_pending);
      end
    end
    tick();
    vblank = 1'b1;
    #1;
    n_checks++;
    if (back_re !== 1'b1 || back_addr !== 4'd2) begin
      n_fail++; $display("FAIL pause_resume: re=%0b addr=%0h required 1 2", back_re, back_addr);
    end
    wait_done(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL pause_timeout: copy not finished required finish"); end
  endtask
`else
  task automatic test_no_gate();
    bit ok;
    load_mem();
    vblank = 1'b0;
    fw_cyc.delete();
    pulse_start();
    wait_done(ok);
    n_checks++;
    if (!ok || fw_cyc.size() != FBW) begin
      n_fail++; $display("FAIL no_gate: ok=%0b writes=%0d required 1 %0d", ok, fw_cyc.size(), FBW);
    end
  endtask
`endif

  task automatic test_cpu_collision();
    bit ok;
    load_mem();
    vblank = 1'b1;
    fw_cyc.delete();
    pulse_start();   // WAIT_VB
    tick();          // first COPY cycle
    tick();          // second COPY cycle
    cpu_we = 1'b1; cpu_addr = 4'd9; cpu_wdata = 8'h5A;
    #1;
    n_checks++;
    if (back_we !== 1'b1 || back_addr !== 4'd9 || back_wdata !== 8'h5A || back_re !== 1'b0) begin
      n_fail++;
      $display("FAIL collision_port: we=%0b addr=%0h wdata=%0h re=%0b required 1 9 5a 0", back_we, back_addr, back_wdata, back_re);
    end
    tick();
    cpu_we = 1'b0;
    wait_done(ok);
    n_checks++;
    if (!ok || fw_cyc.size() != FBW) begin
      n_fail++; $display("FAIL collision_done: ok=%0b writes=%0d required 1 %0d", ok, fw_cyc.size(), FBW);
    end
    n_checks++;
    if (mem[9] !== 8'h5A) begin
      n_fail++; $display("FAIL collision_mem: mem[9]=%0h required 5a", mem[9]);
    end
  endtask

  task automatic test_reset_abort();
    load_mem();
    vblank = 1'b1;
    pulse_start();   // WAIT_VB
    tick();          // issue word 0
    tick();          // issue word 1
    tick();          // rd_ptr = 2
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (copy_pending !== 1'b0 || front_we !== 1'b0 || back_re !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_state: pending=%0b fwe=%0b re=%0b required 0 0 0", copy_pending, front_we, back_re);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (front_we !== 1'b0 || back_re !== 1'b0 || copy_pending !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_no_resume: fwe=%0b re=%0b pending=%0b required 0 0 0", front_we, back_re, copy_pending);
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    for (int n = 0; n < 8; n++) begin
      load_mem();
      fw_cyc.delete();
      vblank = 1'b1;
      pulse_start();
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
        if (!model_busy && copy_pending === 1'b0 && exp_q.size() == 0) begin
          ok = 1'b1;
          break;
        end
        vblank    = ($urandom_range(0, 3) != 0);
        cpu_we    = ($urandom_range(0, 3) == 0);
        cpu_addr  = AW'($urandom_range(4, 15));
        cpu_wdata = DW'($urandom_range(0, 255));
        start     = ($urandom_range(0, 7) == 0);
        tick();
      end
      start = 1'b0; cpu_we = 1'b0;
      n_checks++;
      if (!ok || fw_cyc.size() != FBW) begin
        n_fail++; $display("FAIL random_copy_%0d: ok=%0b writes=%0d required 1 %0d", n, ok, fw_cyc.size(), FBW);
      end
      tick();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
`ifdef FBCOPY_VBLANK_GATE_EN
    test_vblank_hold();
    test_vblank_pause();
`else
    test_no_gate();
`endif
    test_cpu_collision();
    test_reset_abort();
    test_random();
    tick();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL leftover_writes: %0d outstanding required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop in case the test sequence itself stalls.
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
